// File: rtl/pong_pkg.sv
// Shared constants for the ping-pong referee.
// Holds the LED count, the FSM state encoding, the default game parameters
// and a one-hot test used on the ball position bus.
package pong_pkg;

  localparam int NUM_LEDS      = 18;
  localparam int WIN_SCORE_DEF = 7;
  localparam int HIT_ZONE_DEF  = 3;
  localparam int SCORE_W_DEF   = 4;

  localparam logic [0:0] PLAY = 1'b0;
  localparam logic [0:0] OVER = 1'b1;

  // True when exactly one LED is lit: non-zero and clearing the lowest set
  // bit leaves nothing behind.
  function automatic logic is_onehot(input logic [NUM_LEDS-1:0] v);
    logic [NUM_LEDS-1:0] one;
    one = {{(NUM_LEDS-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & (v - one)) == '0);
  endfunction

endpackage

// File: rtl/pong_referee_btn_sync_edge.sv
// Button front end: 2-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk     - system clock
//   reset   - synchronous, active-high
//   i_btn   - raw button, asynchronous to clk
//   o_press - one-cycle pulse per press, high in the cycle after the third
//             edge that samples the button high
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [1:0] r_live;
  logic       r_press;

  // r_live marks when r_sync2 carries a real post-reset sample. Until then
  // r_prev is held high, so a button held through reset never looks like a
  // fresh press; it must be seen low before the next pulse can fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b1;
      r_live  <= 2'b00;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_live  <= {r_live[0], 1'b1};
      r_prev  <= r_live[1] ? r_sync2 : 1'b1;
      r_press <= r_live[1] & r_sync2 & ~r_prev;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/pong_referee.sv
// Ping-pong referee: judges paddle hits at both ends of the 18-LED board,
// keeps both scores and raises the sticky full flags that freeze the ball
// display at game end.
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   btn_left/right    - raw player buttons (asynchronous)
//   ball_leds         - one-hot ball position, bit 17 = left end
//   score_left/right  - saturating point counters
//   point_left/right  - one-cycle pulse when that player scores
//   left/right_full_flag - sticky, that player reached WIN_SCORE
//
// state | meaning
// PLAY  | judging active, scores may change
// OVER  | a player has won; scores, flags frozen until reset
module pong_referee
  import pong_pkg::*;
#(
  parameter int WIN_SCORE = WIN_SCORE_DEF,
  parameter int HIT_ZONE  = HIT_ZONE_DEF,
  parameter int SCORE_W   = SCORE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic [NUM_LEDS-1:0] ball_leds,
  output logic [SCORE_W-1:0]  score_left,
  output logic [SCORE_W-1:0]  score_right,
  output logic                point_left,
  output logic                point_right,
  output logic                left_full_flag,
  output logic                right_full_flag
);

  localparam logic [SCORE_W-1:0] WIN_Q = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE_Q = SCORE_W'(1);

  logic [0:0]         r_state;
  logic               r_zone_l_q;
  logic               r_zone_r_q;
  logic               r_hit_l;
  logic               r_hit_r;
  logic [SCORE_W-1:0] r_score_l;
  logic [SCORE_W-1:0] r_score_r;
  logic               r_point_l;
  logic               r_point_r;
  logic               r_flag_l;
  logic               r_flag_r;

  logic               w_press_l;
  logic               w_press_r;
  logic               w_ball_ok;
  logic               w_zone_l;
  logic               w_zone_r;
  logic               w_judge;
  logic               w_miss_l;
  logic               w_miss_r;
  logic [SCORE_W-1:0] w_score_l_nx;
  logic [SCORE_W-1:0] w_score_r_nx;

  btn_sync_edge u_btn_l (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_left),
    .o_press (w_press_l)
  );

  btn_sync_edge u_btn_r (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_right),
    .o_press (w_press_r)
  );

  assign w_ball_ok = is_onehot(ball_leds);
  assign w_zone_l  = |ball_leds[NUM_LEDS-1 -: HIT_ZONE];
  assign w_zone_r  = |ball_leds[HIT_ZONE-1:0];

  // Invalid ball patterns (game-over all-ones, blank) freeze all judging.
  assign w_judge   = (r_state == PLAY) & w_ball_ok;

  // Ball leaving a zone without a registered hit: the opposite player scores.
  assign w_miss_l  = w_judge & ~w_zone_l & r_zone_l_q & ~r_hit_l;
  assign w_miss_r  = w_judge & ~w_zone_r & r_zone_r_q & ~r_hit_r;

  assign w_score_l_nx = (r_score_l >= WIN_Q) ? WIN_Q : r_score_l + ONE_Q;
  assign w_score_r_nx = (r_score_r >= WIN_Q) ? WIN_Q : r_score_r + ONE_Q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= PLAY;
      r_zone_l_q <= 1'b0;
      r_zone_r_q <= 1'b0;
      r_hit_l    <= 1'b0;
      r_hit_r    <= 1'b0;
      r_score_l  <= '0;
      r_score_r  <= '0;
      r_point_l  <= 1'b0;
      r_point_r  <= 1'b0;
      r_flag_l   <= 1'b0;
      r_flag_r   <= 1'b0;
    end else begin
      r_point_l <= 1'b0;
      r_point_r <= 1'b0;
      if (w_judge) begin
        r_zone_l_q <= w_zone_l;
        r_zone_r_q <= w_zone_r;

        // On entry the hit starts fresh; inside the zone the first press
        // sticks. Leaving (or being outside) clears it.
        if (w_zone_l) r_hit_l <= (r_zone_l_q & r_hit_l) | w_press_l;
        else          r_hit_l <= 1'b0;
        if (w_zone_r) r_hit_r <= (r_zone_r_q & r_hit_r) | w_press_r;
        else          r_hit_r <= 1'b0;

        // Zones are disjoint, so at most one of these fires per cycle.
        if (w_miss_l) begin
          r_score_r <= w_score_r_nx;
          r_point_r <= 1'b1;
          if (w_score_r_nx == WIN_Q) begin
            r_flag_r <= 1'b1;
            r_state  <= OVER;
          end
        end
        if (w_miss_r) begin
          r_score_l <= w_score_l_nx;
          r_point_l <= 1'b1;
          if (w_score_l_nx == WIN_Q) begin
            r_flag_l <= 1'b1;
            r_state  <= OVER;
          end
        end
      end
    end
  end

  assign score_left      = r_score_l;
  assign score_right     = r_score_r;
  assign point_left      = r_point_l;
  assign point_right     = r_point_r;
  assign left_full_flag  = r_flag_l;
  assign right_full_flag = r_flag_r;

endmodule
